// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: stores {err, data} per byte, flags occupancy, sticky overrun.
// Optional build macro UART_RX_FIFO_DROP_ERR_EN: discard error bytes and count them in err_cnt instead.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_err,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_err,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic [7:0]               err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_empty, r_full, r_af, r_overrun;
  logic [DATA_W:0]    r_last;
  logic [DATA_W:0]    w_head;
  logic               w_rd, w_wr, w_drop, w_ovr_set;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic [7:0] r_err_cnt;
  assign w_drop = rx_err;
`else
  assign w_drop = 1'b0;
`endif

  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_rd      = rd_en && !r_empty;
  assign w_wr      = rx_valid && !w_drop && (!r_full || w_rd);
  assign w_ovr_set = rx_valid && !w_drop && r_full && !rd_en;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: the storage array has no reset; contents are only observed behind a valid pointer.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {rx_err, rx_data};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_af      <= 1'b0;
      r_overrun <= 1'b0;
      r_last    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= w_head;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_af    <= (w_count_nxt >= CNT_W'(AF_LVL));
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)                                r_err_cnt <= '0;
    else if (rx_valid && rx_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  // Once drained, the outputs keep showing the last entry popped.
  assign w_head      = r_mem[r_rd_ptr];
  assign rd_data     = r_empty ? r_last[DATA_W-1:0] : w_head[DATA_W-1:0];
  assign rd_err      = r_empty ? r_last[DATA_W]     : w_head[DATA_W];
  assign empty       = r_empty;
  assign full        = r_full;
  assign almost_full = r_af;
  assign count       = r_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue model compared every cycle plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_err = 1'b0, rd_en = 1'b0, clr_overrun = 1'b0;
  logic [7:0] rd_data;
  logic       rd_err, empty, full, almost_full, overrun;
  logic [3:0] count;
  logic [7:0] err_cnt;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_LVL(6)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overrun(overrun),
    .clr_overrun(clr_overrun), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  // Model: queue of {err, data}, last popped entry, sticky overrun, error counter.
  logic [8:0] mq[$];
  logic [8:0] m_last = '0;
  bit         m_ovr = 1'b0;
  int         m_errc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_update(input logic v, input logic [7:0] d, input logic e,
                              input logic r, input logic c, input logic rs);
    bit do_rd, drop, do_wr;
    if (rs) begin
      mq.delete();
      m_last = '0;
      m_ovr  = 1'b0;
      m_errc = 0;
      return;
    end
    do_rd = r && (mq.size() != 0);
    drop  = DROP && e;
    do_wr = v && !drop && (mq.size() < DEPTH || do_rd);
    if (v && drop && m_errc < 255) m_errc++;
    if (v && !drop && mq.size() == DEPTH && !r) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
    if (do_rd) m_last = mq.pop_front();
    if (do_wr) mq.push_back({e, d});
  endtask

  // One clock: drive inputs, advance the model at the edge, return just after it.
  task automatic cycle(input logic v, input logic [7:0] d, input logic e,
                       input logic r, input logic c, input logic rs);
    rx_valid = v; rx_data = d; rx_err = e; rd_en = r; clr_overrun = c; rst = rs;
    @(posedge clk);
    model_update(v, d, e, r, c, rs);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [8:0] exp_hd;
      exp_hd = (mq.size() != 0) ? mq[0] : m_last;
      check("cmp_rd_data", rd_data, exp_hd[7:0]);
      check("cmp_rd_err", rd_err, exp_hd[8]);
      check("cmp_count", count, mq.size());
      check("cmp_empty", empty, mq.size() == 0);
      check("cmp_full", full, mq.size() == DEPTH);
      check("cmp_almost_full", almost_full, mq.size() >= 6);
      check("cmp_overrun", overrun, m_ovr);
      check("cmp_err_cnt", err_cnt, m_errc);
    end
  end

  initial begin
    logic [7:0] last_rd;
    // 1: reset, two writes, one read
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_overrun", overrun, 0);
    push(8'h5A);
    check("t1_latency_empty", empty, 0);
    push(8'hA5);
    check("t1_count2", count, 2);
    check("t1_head", rd_data, 8'h5A);
    pop();
    check("t1_after_pop", rd_data, 8'hA5);
    check("t1_count1", count, 1);
    pop();
    check("t1_hold_last", rd_data, 8'hA5);

    // 2: fill, overrun (set beats clear), drain order
    for (int i = 0; i < 8; i++) begin
      push(8'(i));
      check("t2_almost_full", almost_full, (i + 1) >= 6);
    end
    check("t2_full", full, 1);
    push(8'hFF);
    check("t2_overrun", overrun, 1);
    check("t2_count8", count, 8);
    cycle(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_set_beats_clr", overrun, 1);
    for (int i = 0; i < 8; i++) begin
      check("t2_drain_order", rd_data, 8'(i));
      pop();
    end
    check("t2_drained_empty", empty, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_clr_overrun", overrun, 0);

    // 3: full with simultaneous write and read
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    cycle(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_count8", count, 8);
    check("t3_no_overrun", overrun, 0);
    check("t3_head", rd_data, 8'h11);
    last_rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last_rd = rd_data;
      pop();
    end
    check("t3_last_byte", last_rd, 8'h80);

    // 4: reads on empty ignored, then write+read on empty
    for (int i = 0; i < 3; i++) pop();
    check("t4_count0", count, 0);
    check("t4_empty", empty, 1);
    cycle(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_count1", count, 1);
    check("t4_data", rd_data, 8'h3C);
    pop();

    // 5: error byte
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    check("t5_drop_count", count, 0);
    check("t5_err_cnt", err_cnt, 1);
`else
    check("t5_rd_err", rd_err, 1);
    check("t5_count", count, 1);
    check("t5_data", rd_data, 8'hAA);
    pop();
`endif

    // 6: reset mid-stream discards contents
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_count0", count, 0);
    check("t6_empty", empty, 1);
    check("t6_overrun", overrun, 0);
    push(8'h11);
    check("t6_first", rd_data, 8'h11);
    check("t6_count1", count, 1);
    pop();

    chk_en = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
